// File: rtl/countdown_arbiter.sv
// Round-robin arbiter that lends a single shared down counter to one requester
// at a time; the owner gets a one-cycle done pulse when its countdown expires.
module countdown_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   load_val,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        count,
  output logic [NREQ-1:0]         done,
  output logic                    busy
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic [WIDTH-1:0]  count_q;
  logic              busy_q;
  logic [IDXW-1:0]   last_q;

  logic              found_d;
  logic [IDXW-1:0]   cand_d;
  logic [IDXW-1:0]   win_d;
  logic [WIDTH-1:0]  win_load_d;
  logic [NREQ-1:0]   win_gnt_d;
  logic              owner_req_d;

  // Round-robin search from last+1 upward, plus the winner's grant and start value.
  always_comb begin
    found_d    = 1'b0;
    cand_d     = {IDXW{1'b0}};
    win_d      = last_q;
    win_load_d = {WIDTH{1'b0}};
    win_gnt_d  = {NREQ{1'b0}};
    for (int i = 1; i <= NREQ; i++) begin
      cand_d  = IDXW'((int'(last_q) + i) % NREQ);
      win_d   = (!found_d && req[cand_d]) ? cand_d : win_d;
      found_d = found_d | req[cand_d];
    end
    for (int k = 0; k < NREQ; k++) begin
      win_load_d   = (int'(win_d) == k) ? load_val[k*WIDTH +: WIDTH] : win_load_d;
      win_gnt_d[k] = (int'(win_d) == k);
    end
    owner_req_d = |(req & gnt_q);
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= {NREQ{1'b0}};
      done_q  <= {NREQ{1'b0}};
      count_q <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      last_q  <= IDXW'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= {NREQ{1'b0}};
          if (found_d) begin
            gnt_q   <= win_gnt_d;
            count_q <= win_load_d;
            last_q  <= win_d;
            busy_q  <= 1'b1;
            state_q <= COUNT;
          end else begin
            gnt_q   <= {NREQ{1'b0}};
            busy_q  <= 1'b0;
          end
        end
        COUNT: begin
          // A dropped owner request wins even over an expiring count.
          if (!owner_req_d) begin
            gnt_q   <= {NREQ{1'b0}};
            count_q <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (count_q != {WIDTH{1'b0}}) begin
            count_q <= count_q - {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            done_q  <= gnt_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          gnt_q   <= {NREQ{1'b0}};
          done_q  <= {NREQ{1'b0}};
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= {NREQ{1'b0}};
          done_q  <= {NREQ{1'b0}};
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign count = count_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_countdown_arbiter.sv
// Directed bench for countdown_arbiter (WIDTH=4, NREQ=4) with hand-computed expectations.
module tb_countdown_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] load_val;
  logic [3:0]  gnt;
  logic [3:0]  count;
  logic [3:0]  done;
  logic        busy;

  int checks;
  int failures;

  countdown_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .load_val(load_val),
    .gnt(gnt), .count(count), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; load_val = 16'h1234;
    #1;
    checks++;
    if ({gnt, count, done, busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset_immediate gnt=%b count=%0d done=%b busy=%b exp all 0", gnt, count, done, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({gnt, count, done, busy} !== 13'd0) begin
        failures++;
        $display("FAIL reset_hold%0d gnt=%b count=%0d done=%b busy=%b exp all 0", i, gnt, count, done, busy);
      end
    end
    rst = 1'b0; req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset gnt=%b busy=%b exp 0000/0", gnt, busy);
    end
  endtask

  task automatic test_single();
    load_val = 16'h0003; req = 4'b0001;
    tick();  // E1
    checks++;
    if (gnt !== 4'b0001 || count !== 4'd3 || busy !== 1'b1 || done !== 4'b0000) begin
      failures++;
      $display("FAIL single_grant gnt=%b count=%0d busy=%b done=%b exp 0001/3/1/0000", gnt, count, busy, done);
    end
    load_val = 16'h000F;  // must not disturb the running count
    tick();  // E2
    checks++;
    if (count !== 4'd2) begin
      failures++;
      $display("FAIL single_e2 count=%0d exp 2", count);
    end
    req = 4'b0011;  // non-owner request is ignored while counting
    tick();  // E3
    checks++;
    if (count !== 4'd1 || gnt !== 4'b0001) begin
      failures++;
      $display("FAIL single_e3 count=%0d gnt=%b exp 1/0001", count, gnt);
    end
    tick();  // E4
    checks++;
    if (count !== 4'd0 || done !== 4'b0000) begin
      failures++;
      $display("FAIL single_e4 count=%0d done=%b exp 0/0000", count, done);
    end
    tick();  // E5
    checks++;
    if (done !== 4'b0001 || gnt !== 4'b0001 || count !== 4'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_done done=%b gnt=%b count=%0d busy=%b exp 0001/0001/0/1", done, gnt, count, busy);
    end
    req = 4'b0000;
    tick();  // E6
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin
      failures++;
      $display("FAIL single_end gnt=%b busy=%b done=%b exp 0000/0/0000", gnt, busy, done);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    rst = 1'b1; #1; rst = 1'b0;
    load_val = 16'h1111; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      tick();
      checks++;
      if (gnt !== eg || count !== 4'd1 || done !== 4'b0000) begin
        failures++;
        $display("FAIL rr_grant%0d gnt=%b count=%0d done=%b exp %b/1/0000", k, gnt, count, done, eg);
      end
      tick();
      tick();
      checks++;
      if (done !== eg || gnt !== eg) begin
        failures++;
        $display("FAIL rr_done%0d done=%b gnt=%b exp %b", k, done, gnt, eg);
      end
      tick();
      checks++;
      if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rr_idle%0d gnt=%b done=%b busy=%b exp 0000/0000/0", k, gnt, done, busy);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_abort();
    load_val = 16'h0090; req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010 || count !== 4'd9) begin
      failures++;
      $display("FAIL abort_grant gnt=%b count=%0d exp 0010/9", gnt, count);
    end
    repeat (4) tick();
    checks++;
    if (count !== 4'd5) begin
      failures++;
      $display("FAIL abort_pre count=%0d exp 5", count);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || count !== 4'd0 || busy !== 1'b0 || done !== 4'b0000) begin
      failures++;
      $display("FAIL abort_edge gnt=%b count=%0d busy=%b done=%b exp 0000/0/0/0000", gnt, count, busy, done);
    end
    tick();
    checks++;
    if (done !== 4'b0000 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL abort_after done=%b gnt=%b exp 0000/0000", done, gnt);
    end
    // Abort at count==0 must win over the transition to DONE.
    load_val = 16'h0000; req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || count !== 4'd0) begin
      failures++;
      $display("FAIL abort0_grant gnt=%b count=%0d exp 0100/0", gnt, count);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort0_edge gnt=%b done=%b busy=%b exp 0000/0000/0", gnt, done, busy);
    end
  endtask

  task automatic test_boundary(input logic [3:0] lv);
    int exp_c;
    load_val = {lv, 12'h000}; req = 4'b1000;
    tick();  // grant edge is edge 1
    checks++;
    if (gnt !== 4'b1000 || count !== lv) begin
      failures++;
      $display("FAIL bnd%0d_grant gnt=%b count=%0d exp 1000/%0d", lv, gnt, count, lv);
    end
    for (int n = 2; n <= int'(lv) + 2; n++) begin
      tick();
      checks++;
      if (n <= int'(lv) + 1) begin
        exp_c = int'(lv) - (n - 1);
        if (int'(count) !== exp_c || done !== 4'b0000) begin
          failures++;
          $display("FAIL bnd%0d_e%0d count=%0d done=%b exp %0d/0000", lv, n, count, done, exp_c);
        end
      end else begin
        if (done !== 4'b1000 || count !== 4'd0) begin
          failures++;
          $display("FAIL bnd%0d_done done=%b count=%0d exp 1000/0", lv, done, count);
        end
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || done !== 4'b0000 || count !== 4'd0) begin
      failures++;
      $display("FAIL bnd%0d_end gnt=%b done=%b count=%0d exp 0000/0000/0", lv, gnt, done, count);
    end
  endtask

  task automatic test_async_reset();
    load_val = 16'h0009; req = 4'b0001;
    tick();
    repeat (3) tick();
    checks++;
    if (count !== 4'd6 || gnt !== 4'b0001) begin
      failures++;
      $display("FAIL areset_pre count=%0d gnt=%b exp 6/0001", count, gnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || count !== 4'd0 || busy !== 1'b0 || done !== 4'b0000) begin
      failures++;
      $display("FAIL areset_now gnt=%b count=%0d busy=%b done=%b exp all 0", gnt, count, busy, done);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || count !== 4'd9 || done !== 4'b0000) begin
      failures++;
      $display("FAIL areset_rearb gnt=%b count=%0d done=%b exp 0001/9/0000", gnt, count, done);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin
      failures++;
      $display("FAIL areset_end gnt=%b busy=%b done=%b exp 0000/0/0000", gnt, busy, done);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; req = 4'b0000; load_val = 16'h0000;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_boundary(4'd0);
    test_boundary(4'd15);
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
